mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, port ids and helpers for the two-port memory arbiter.
// Round-robin arbitration is selected with the MEM_ARB_RR_EN macro.
package mem_port_arbiter_pkg;

    localparam int ADDR      = 16;
    localparam int WORD      = 32;
    localparam int ARB_CNT_W = 3;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_P0   = 2'b01,
        GNT_P1   = 2'b10
    } gnt_e;

    typedef struct packed {
        logic            we;
        logic [ADDR-1:0] addr;
        logic [WORD-1:0] wdata;
    } mem_cmd_t;

    function automatic logic [ARB_CNT_W-1:0] sat_inc(
        input logic [ARB_CNT_W-1:0] v,
        input logic [ARB_CNT_W-1:0] lim
    );
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection for the memory arbiter (one-hot grant).
// MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation guard.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic                 req0,
    input  logic                 req1,
`ifdef MEM_ARB_RR_EN
    input  logic                 rr_last,
`else
    input  logic [ARB_CNT_W-1:0] wait_cnt,
`endif
    output gnt_e                 gnt
);

`ifndef MEM_ARB_RR_EN
    localparam logic [ARB_CNT_W-1:0] LIM = ARB_CNT_W'(STARVE_LIM);
`endif

    logic p0_wins;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // the port that was not granted last time takes the conflict
        p0_wins = (rr_last == ARB_P1);
`else
        // port 1 owns conflicts until port 0 has waited the full limit
        p0_wins = (wait_cnt == LIM);
`endif
        gnt = GNT_NONE;
        if (req0 && req1) begin
            gnt = p0_wins ? GNT_P0 : GNT_P1;
        end else if (req0) begin
            gnt = GNT_P0;
        end else if (req1) begin
            gnt = GNT_P1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory with 1-cycle read latency.
// Define MEM_ARB_RR_EN for round-robin conflicts; default is fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [ADDR-1:0] addr0,
    input  logic [ADDR-1:0] addr1,
    input  logic [WORD-1:0] wdata0,
    input  logic [WORD-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [WORD-1:0] rdata0,
    output logic [WORD-1:0] rdata1,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    gnt_e     pick;
    mem_cmd_t cmd;
    logic     rvalid0_q, rvalid0_d;
    logic     rvalid1_q, rvalid1_d;

`ifdef MEM_ARB_RR_EN
    logic rr_last_q, rr_last_d;

    mem_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last_q),
        .gnt     (pick)
    );
`else
    localparam logic [ARB_CNT_W-1:0] LIM = ARB_CNT_W'(STARVE_LIM);

    logic [ARB_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    mem_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
        .req0     (req0),
        .req1     (req1),
        .wait_cnt (wait_cnt_q),
        .gnt      (pick)
    );
`endif

    // no grant can escape while the arbiter is held in reset
    assign gnt0 = rst & (pick == GNT_P0);
    assign gnt1 = rst & (pick == GNT_P1);

    always_comb begin
        cmd = '0;
        if (gnt0) begin
            cmd.we    = we0;
            cmd.addr  = addr0;
            cmd.wdata = wdata0;
        end else if (gnt1) begin
            cmd.we    = we1;
            cmd.addr  = addr1;
            cmd.wdata = wdata1;
        end
    end

    assign mem_a = cmd.addr;
    assign mem_w = cmd.we;
    assign mem_d = cmd.wdata;

    assign rvalid0_d = gnt0 & ~we0;
    assign rvalid1_d = gnt1 & ~we1;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt0) begin
            rr_last_d = ARB_P0;
        end else if (gnt1) begin
            rr_last_d = ARB_P1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rr_last_q <= ARB_P1;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rr_last_q <= rr_last_d;
        end
    end
`else
    always_comb begin
        wait_cnt_d = sat_inc(wait_cnt_q, LIM);
        if (gnt0 || !req0) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // the memory's registered Q goes to both ports; rvalid says whose it is
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-mid-read sequence and
// randomized traffic against a behavioural model (honours MEM_ARB_RR_EN).
module tb_mem_port_arbiter;

    localparam int LIM = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_w;
    logic [31:0] rdata0, rdata1, mem_d, mem_q;
    logic [15:0] mem_a;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'(a) * 32'h9E3779B1 + 32'h0000_1234;
    endfunction

    // memory: registered read data, Q holds during a write
    bit [31:0] mem    [65536];
    bit        mem_ok [65536];
    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_a]    <= mem_d;
            mem_ok[mem_a] <= 1'b1;
        end else begin
            mem_q <= mem_ok[mem_a] ? mem[mem_a] : init_word(int'(mem_a));
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // behavioural model state
    logic [31:0] gold [65536];
    int          m_wait;
    int          m_rr;
    bit          m_rv0, m_rv1;
    logic [31:0] m_rdata;
    int          last_win;

    task automatic model_step(input string tag);
        int win;
        logic [31:0] ea, ew, ed;
        if (!rst) begin
            m_rv0 = 0; m_rv1 = 0; m_wait = 0; m_rr = 1;
        end
        chk({tag, " rvalid0"}, 32'(rvalid0), 32'(m_rv0));
        chk({tag, " rvalid1"}, 32'(rvalid1), 32'(m_rv1));
        if (m_rv0) chk({tag, " rdata0"}, rdata0, m_rdata);
        if (m_rv1) chk({tag, " rdata1"}, rdata1, m_rdata);
        win = -1;
        if (rst) begin
            if (req0 && req1) win = RR ? ((m_rr == 1) ? 0 : 1) : ((m_wait >= LIM) ? 0 : 1);
            else if (req0) win = 0;
            else if (req1) win = 1;
        end
        chk({tag, " gnt0"}, 32'(gnt0), 32'(win == 0));
        chk({tag, " gnt1"}, 32'(gnt1), 32'(win == 1));
        ea = (win == 0) ? 32'(addr0)  : (win == 1) ? 32'(addr1)  : 32'd0;
        ew = (win == 0) ? 32'(we0)    : (win == 1) ? 32'(we1)    : 32'd0;
        ed = (win == 0) ? wdata0      : (win == 1) ? wdata1      : 32'd0;
        chk({tag, " mem_a"}, 32'(mem_a), ea);
        chk({tag, " mem_w"}, 32'(mem_w), ew);
        chk({tag, " mem_d"}, mem_d, ed);
        m_rv0 = (win == 0) && !we0;
        m_rv1 = (win == 1) && !we1;
        if (win >= 0) begin
            if (ew[0]) gold[ea[15:0]] = ed;
            else       m_rdata = gold[ea[15:0]];
            m_rr = win;
        end
        if (!rst || win == 0 || !req0) m_wait = 0;
        else if (m_wait < LIM) m_wait++;
        last_win = win;
    endtask

    typedef struct {
        logic        rst, req0, we0;
        logic [15:0] a0;
        logic [31:0] d0;
        logic        req1, we1;
        logic [15:0] a1;
        logic [31:0] d1;
        logic        g0, g1, rv0, rv1, mw, rdchk;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic q0, input logic w0, input logic [15:0] a0,
                       input logic [31:0] d0, input logic q1, input logic w1, input logic [15:0] a1,
                       input logic [31:0] d1, input logic g0, input logic g1, input logic rv0,
                       input logic rv1, input logic mw, input logic rdchk, input logic [31:0] rd);
        vec_t v;
        v.rst = r; v.req0 = q0; v.we0 = w0; v.a0 = a0; v.d0 = d0;
        v.req1 = q1; v.we1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.mw = mw; v.rdchk = rdchk; v.rd = rd;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic q0, input logic w0, input logic [15:0] a0,
                         input logic [31:0] d0, input logic q1, input logic w1,
                         input logic [15:0] a1, input logic [31:0] d1);
        rst = r; req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        model_step(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pg0, pg1, g0k;
        for (int i = 0; i < 65536; i++) gold[i] = init_word(i);
        m_wait = 0; m_rr = 1; m_rv0 = 0; m_rv1 = 0; m_rdata = '0; last_win = -1;

        // reset with both ports requesting writes: nothing may be granted
        add(0, 1,1,16'h0020,32'h1111_1111, 1,1,16'h0030,32'h2222_2222, 0,0, 0,0, 0, 0, 32'h0);
        // held conflict straight out of reset
        pg0 = 0; pg1 = 0;
        for (int k = 0; k < 5; k++) begin
            g0k = RR ? (k % 2 == 0) : (k == 4);
            add(1, 1,0,16'h0020,32'h0, 1,0,16'h0030,32'h0, g0k, !g0k, pg0, pg1, 0, 0, 32'h0);
            pg0 = g0k; pg1 = !g0k;
        end
        // back-to-back read of 0x0010 while the previous port-0 read returns
        add(1, 1,0,16'h0010,32'h0, 0,0,16'h0,32'h0, 1,0, 1,0, 0, 1, init_word(16'h0020));
        add(1, 0,0,16'h0000,32'h0, 0,0,16'h0,32'h0, 0,0, 1,0, 0, 1, init_word(16'h0010));
        // port 1 writes, port 0 reads the same word next cycle
        add(1, 0,0,16'h0000,32'h0, 1,1,16'h0100,32'hDEAD_BEEF, 0,1, 0,0, 1, 0, 32'h0);
        add(1, 1,0,16'h0100,32'h0, 0,0,16'h0000,32'h0, 1,0, 0,0, 0, 0, 32'h0);
        add(1, 0,0,16'h0000,32'h0, 0,0,16'h0000,32'h0, 0,0, 1,0, 0, 1, 32'hDEAD_BEEF);
        // fresh conflict: port 1 wins in either mode at this point
        add(1, 1,0,16'h0200,32'h0, 1,0,16'h0300,32'h0, 0,1, 0,0, 0, 0, 32'h0);
        add(1, 0,0,16'h0000,32'h0, 0,0,16'h0000,32'h0, 0,0, 0,1, 0, 1, init_word(16'h0300));

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("row%0d", i);
            drive(tbl[i].rst, tbl[i].req0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                  tbl[i].req1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            model_step({t, " model"});
            chk({t, " gnt0"},    32'(gnt0),    32'(tbl[i].g0));
            chk({t, " gnt1"},    32'(gnt1),    32'(tbl[i].g1));
            chk({t, " rvalid0"}, 32'(rvalid0), 32'(tbl[i].rv0));
            chk({t, " rvalid1"}, 32'(rvalid1), 32'(tbl[i].rv1));
            chk({t, " mem_w"},   32'(mem_w),   32'(tbl[i].mw));
            if (tbl[i].rdchk) chk({t, " rdata"}, tbl[i].rv0 ? rdata0 : rdata1, tbl[i].rd);
            @(posedge clk);
            #1;
        end

        // reset lands while a read is in flight: its rvalid must never appear
        drive(1, 1,0,16'h0040,32'h0, 0,0,16'h0,32'h0);
        cyc("t6 grant");
        chk("t6 rvalid0 before reset", 32'(rvalid0), 32'd1);
        drive(0, 0,0,16'h0,32'h0, 0,0,16'h0,32'h0);
        #1;
        chk("t6 rvalid0 dropped", 32'(rvalid0), 32'd0);
        cyc("t6 in reset");
        chk("t6 rvalid0 after edge", 32'(rvalid0), 32'd0);
        drive(1, 1,0,16'h0010,32'h0, 0,0,16'h0,32'h0);
        cyc("t6 reread");
        drive(1, 0,0,16'h0,32'h0, 0,0,16'h0,32'h0);
        @(negedge clk);
        model_step("t6 return");
        chk("t6 rdata0", rdata0, init_word(16'h0010));
        @(posedge clk);
        #1;

        // random traffic; a port keeps its request stable until granted
        for (int c = 0; c < 800; c++) begin
            if (!req0 || last_win == 0) begin
                req0   = ($urandom_range(0, 99) < 55);
                we0    = ($urandom_range(0, 3) == 0);
                addr0  = 16'($urandom_range(0, 7));
                wdata0 = $urandom;
            end
            if (!req1 || last_win == 1) begin
                req1   = ($urandom_range(0, 99) < 80);
                we1    = ($urandom_range(0, 2) == 0);
                addr1  = 16'($urandom_range(0, 7));
                wdata1 = $urandom;
            end
            rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            cyc($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
